// File: rtl/fix_to_float_conv.sv
// Signed fixed-point to sign/exponent/mantissa float converter.
// Iterative normaliser (one left shift per clock) with selectable truncate / round-nearest-even.
module fix_to_float_conv #(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 8,
  parameter int EXP_W  = 5,
  parameter int MAN_W  = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   rnd_mode,
  input  logic [IN_W-1:0]        fix_in,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   flt_out
);

  localparam int BIAS        = 2 ** (EXP_W - 1) - 1;
  localparam int EXP_START_I = BIAS + IN_W - 1 - FRAC_W;
  localparam int EXP_LIMIT   = 2 ** EXP_W - 2;
  // Bit just below the stored mantissa once the leading one sits in the MSB.
  localparam int GUARD_IDX   = IN_W - 2 - MAN_W;

  localparam logic [EXP_W-1:0] EXP_START   = EXP_W'(EXP_START_I);
  localparam logic [IN_W-1:0]  STICKY_MASK = IN_W'((64'(1) << GUARD_IDX) - 64'(1));

  // Parameter sets that could produce denormals, infinities or a missing guard bit are rejected.
  if (IN_W < MAN_W + 2) begin : g_bad_in_w
    $error("fix_to_float_conv: IN_W must be at least MAN_W+2");
  end
  if (BIAS - FRAC_W < 1) begin : g_bad_underflow
    $error("fix_to_float_conv: smallest magnitude would underflow the exponent");
  end
  if (EXP_START_I > EXP_LIMIT) begin : g_bad_overflow
    $error("fix_to_float_conv: largest magnitude would overflow the exponent");
  end

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t state, next_state;

  logic [IN_W-1:0]  mag;
  logic [EXP_W-1:0] exp_q;
  logic             sgn;
  logic             rnd;
  logic             zero;

  logic             accept;
  logic [MAN_W-1:0] man_trunc;
  logic             guard;
  logic             sticky;
  logic             round_up;
  logic [MAN_W:0]   man_sum;
  logic [MAN_W-1:0] man_rnd;
  logic [EXP_W-1:0] exp_rnd;

  assign busy   = (state == ABS) || (state == NORM) || (state == ROUND);
  assign done   = (state == DONE);
  assign accept = start && !busy;

  // NOTE: every register is written with <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state takes its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: begin
        if (start) next_state = ABS;
      end
      ABS: begin
        next_state = (mag == '0) ? ROUND : NORM;
      end
      NORM: begin
        if (mag[IN_W-1]) next_state = ROUND;
      end
      ROUND: begin
        next_state = DONE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // NOTE: the working datapath carries no reset; the FSM alone decides when its contents matter.
  always_ff @(posedge clk) begin
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          mag   <= fix_in;
          sgn   <= fix_in[IN_W-1];
          rnd   <= rnd_mode;
          exp_q <= EXP_START;
          zero  <= 1'b0;
        end
      end
      ABS: begin
        // Two's-complement negate; the most negative operand lands on 2**(IN_W-1) by itself.
        mag  <= sgn ? (IN_W'(0) - mag) : mag;
        zero <= (mag == '0);
      end
      NORM: begin
        if (!mag[IN_W-1]) begin
          mag   <= mag << 1;
          exp_q <= exp_q - EXP_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Rounding is evaluated from the normalised magnitude; only the ROUND edge consumes it.
  always_comb begin
    man_trunc = mag[IN_W-2 -: MAN_W];
    guard     = mag[GUARD_IDX];
    sticky    = |(mag & STICKY_MASK);
    round_up  = rnd && guard && (sticky || man_trunc[0]);
    man_sum   = {1'b0, man_trunc} + (MAN_W+1)'(round_up);
    man_rnd   = man_sum[MAN_W-1:0];
    exp_rnd   = exp_q + EXP_W'(man_sum[MAN_W]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flt_out <= '0;
    end else if (state == ROUND) begin
      flt_out <= zero ? '0 : {sgn, exp_rnd, man_rnd};
    end
  end

endmodule

// File: tb/tb_fix_to_float_conv.sv
// Directed bench for fix_to_float_conv at Q8.8 -> fp16 defaults.
// Expected results and latencies queue up at launch and are popped when done rises.
module tb_fix_to_float_conv;

  localparam int IN_W  = 16;
  localparam int FLT_W = 16;
  localparam int LIMIT = 64;

  typedef struct packed {
    logic [FLT_W-1:0] flt;
    logic [7:0]       lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             rnd_mode;
  logic [IN_W-1:0]  fix_in;
  logic             busy;
  logic             done;
  logic [FLT_W-1:0] flt_out;

  int               total = 0;
  int               bad   = 0;
  exp_t             sb[$];
  logic [FLT_W-1:0] prev_flt;

  always #5 clk = ~clk;

  fix_to_float_conv dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rnd_mode (rnd_mode),
    .fix_in   (fix_in),
    .busy     (busy),
    .done     (done),
    .flt_out  (flt_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called right after a negedge; returns right after the negedge on which done is seen.
  // pulse_at >= 0 drives a competing start (operand 7FFF) that many edges after acceptance.
  task automatic convert(input logic [IN_W-1:0] fx, input logic rm, input logic [FLT_W-1:0] exp_flt,
                         input int exp_lat, input string tag, input int pulse_at);
    exp_t e;
    int   edges;
    start    = 1'b1;
    fix_in   = fx;
    rnd_mode = rm;
    sb.push_back('{flt: exp_flt, lat: 8'(exp_lat)});
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    fix_in   = 16'($urandom);
    rnd_mode = 1'($urandom);
    check({tag, " accept busy"}, 32'(busy), 32'd1);
    check({tag, " accept done"}, 32'(done), 32'd0);
    check({tag, " held flt"}, 32'(flt_out), 32'(prev_flt));
    edges = 0;
    while (!done && edges < LIMIT) begin
      if (edges == pulse_at) begin
        start  = 1'b1;
        fix_in = 16'h7FFF;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    start = 1'b0;
    e = sb.pop_front();
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " latency"}, 32'(edges), 32'(e.lat));
    check({tag, " flt"}, 32'(flt_out), 32'(e.flt));
    prev_flt = e.flt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rnd_mode = 1'b0;
    fix_in   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset flt", 32'(flt_out), 32'd0);
    reset    = 1'b0;
    prev_flt = '0;

    // Reference vectors; each launch also exercises back-to-back start from DONE.
    convert(16'h0100, 1'b0, 16'h3C00, 10, "one", -1);
    convert(16'hFF00, 1'b0, 16'hBC00, 10, "minus_one", -1);
    convert(16'h8000, 1'b0, 16'hD800, 3,  "min_neg", -1);
    convert(16'h0000, 1'b1, 16'h0000, 2,  "zero", -1);
    convert(16'h0001, 1'b0, 16'h1C00, 18, "lsb", -1);
    convert(16'h7FFF, 1'b0, 16'h57FF, 4,  "max_trunc", -1);
    convert(16'h7FFF, 1'b1, 16'h5800, 4,  "max_rne_carry", -1);
    convert(16'h0801, 1'b1, 16'h4800, 7,  "tie_even", -1);
    convert(16'h0803, 1'b1, 16'h4802, 7,  "tie_odd", -1);
    convert(16'h0803, 1'b0, 16'h4801, 7,  "tie_odd_trunc", -1);
    convert(16'hF7FD, 1'b1, 16'hC802, 7,  "neg_tie_odd", -1);
    convert(16'hFFFF, 1'b1, 16'h9C00, 18, "neg_lsb", -1);
    convert(16'h0100, 1'b0, 16'h3C00, 10, "start_while_busy", 3);

    // Abort mid-normalisation: no result, outputs back to reset values.
    start    = 1'b1;
    fix_in   = 16'h0001;
    rnd_mode = 1'b0;
    sb.push_back('{flt: 16'h1C00, lat: 8'd18});
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("abort pre busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort done", 32'(done), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort flt", 32'(flt_out), 32'd0);
    void'(sb.pop_front());
    reset    = 1'b0;
    prev_flt = '0;
    @(posedge clk);
    @(negedge clk);
    check("abort idle done", 32'(done), 32'd0);

    convert(16'h0100, 1'b1, 16'h3C00, 10, "after_abort", -1);

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
